// File: rtl/block_cx_src_if.sv
// Shared pieces of the hierIncludeC subsystem: the package with default
// sizing for the link, and the rdy_vld_if ready/valid link interface.
// A source drives vld/data and samples rdy; a destination does the reverse.

package hierIncludeC_package;
    localparam int HIC_DATA_W = 8;
    localparam int HIC_DEPTH  = 4;
    localparam int HIC_GAP_W  = 4;
endpackage

interface rdy_vld_if #(
    parameter int DATA_W = 8
) ();
    logic              vld;
    logic              rdy;
    logic [DATA_W-1:0] data;

    modport src (output vld, output data, input  rdy);
    modport dst (input  vld, input  data, output rdy);
endinterface

// File: rtl/block_cx_src.sv
// block_cx_src: transmitter end of an rdy_vld_if link.
// A local producer pushes words into a DEPTH-entry FIFO; the head word is
// presented on x with ready/valid semantics. After every accepted beat the
// link can be forced idle for gap_cfg cycles. flush drops queued words but
// never retracts a head that is already being presented.
// Optional build macro BLOCK_CX_SRC_STATS_EN adds beat_cnt and stall_cnt.

module block_cx_src
    import hierIncludeC_package::*;
#(
    parameter int DATA_W = HIC_DATA_W,
    parameter int DEPTH  = HIC_DEPTH,
    parameter int GAP_W  = HIC_GAP_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    rdy_vld_if.src                     x,
    input  logic                       push_vld,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       push_rdy,
    input  logic [GAP_W-1:0]           gap_cfg,
    input  logic                       flush,
`ifdef BLOCK_CX_SRC_STATS_EN
    output logic [15:0]                beat_cnt,
    output logic [15:0]                stall_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int LVL_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               init_q, init_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               full;
    logic               push_acc;
    logic               sending;
    logic               pop;
    logic [PTR_W-1:0]   base;
    logic [PTR_W-1:0]   lvl_d;
    logic [DATA_W-1:0]  head_d;

    // FIFO bookkeeping. On flush the write pointer collapses onto the read
    // pointer, skipping over the presented head when in SEND; a same-cycle
    // push lands right behind whatever is retained. head_d bypasses the
    // push word when it is written into the slot that becomes the new head.
    always_comb begin
        full     = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        push_rdy = init_q && !full;
        push_acc = push_vld && push_rdy;
        sending  = (state_q == SEND);
        pop      = sending && x.rdy;
        base     = flush ? (rd_ptr_q + PTR_W'(sending)) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = base + PTR_W'(push_acc);
        lvl_d    = wr_ptr_d - rd_ptr_d;
        head_d   = (push_acc && (base[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]))
                   ? push_data : mem_q[rd_ptr_d[IDX_W-1:0]];
        init_d   = 1'b1;
    end

    // Next-state logic; data_q is only reloaded on entry into SEND so the
    // presented word cannot move until its handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (!flush && lvl_d != '0) begin
                    state_d = SEND;
                    data_d  = head_d;
                end
            end
            SEND: begin
                if (pop) begin
                    if (gap_cfg != '0) begin
                        state_d = GAP;
                        cnt_d   = gap_cfg;
                    end else if (lvl_d != '0) begin
                        data_d  = head_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == GAP_W'(1)) begin
                    if (lvl_d != '0) begin
                        state_d = SEND;
                        data_d  = head_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            init_q   <= init_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[base[IDX_W-1:0]] <= push_data;
    end

    assign x.vld  = (state_q == SEND);
    assign x.data = data_q;
    assign level  = LVL_W'(wr_ptr_q - rd_ptr_q);

`ifdef BLOCK_CX_SRC_STATS_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Link statistics: beats wrap, stalls saturate; flush leaves both alone.
    always_comb begin
        beat_cnt_d  = beat_cnt_q + 16'(pop);
        stall_cnt_d = stall_cnt_q;
        if (sending && !x.rdy && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_block_cx_src.sv
// Directed bench for block_cx_src: reset, streaming, backpressure, gap,
// flush (with and without a same-cycle push), reset mid-burst, and the
// optional statistics counters when BLOCK_CX_SRC_STATS_EN is defined.

module tb_block_cx_src;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push_vld;
    logic [7:0] push_data;
    logic       push_rdy;
    logic [3:0] gap_cfg;
    logic       flush;
    logic [2:0] level;
`ifdef BLOCK_CX_SRC_STATS_EN
    logic [15:0] beat_cnt;
    logic [15:0] stall_cnt;
`endif

    int nchk = 0;
    int nerr = 0;

    rdy_vld_if #(.DATA_W(8)) x_if ();

    block_cx_src #(.DATA_W(8), .DEPTH(4), .GAP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x_if),
        .push_vld  (push_vld),
        .push_data (push_data),
        .push_rdy  (push_rdy),
        .gap_cfg   (gap_cfg),
        .flush     (flush),
`ifdef BLOCK_CX_SRC_STATS_EN
        .beat_cnt  (beat_cnt),
        .stall_cnt (stall_cnt),
`endif
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_q [4];
    logic       vpat [9];

    initial begin
        rst_n     = 1'b0;
        push_vld  = 1'b0;
        push_data = 8'h00;
        gap_cfg   = 4'd0;
        flush     = 1'b0;
        x_if.rdy  = 1'b0;
        tick();
        tick();
        chk("rst_vld",   32'(x_if.vld),  32'd0);
        chk("rst_data",  32'(x_if.data), 32'd0);
        chk("rst_level", 32'(level),     32'd0);
        chk("rst_prdy",  32'(push_rdy),  32'd0);
`ifdef BLOCK_CX_SRC_STATS_EN
        chk("rst_beat",  32'(beat_cnt),  32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("rel_prdy",  32'(push_rdy),  32'd1);

        // Stream: three words back-to-back, one beat per clock.
        x_if.rdy = 1'b1;
        push_vld = 1'b1; push_data = 8'h11; tick();
        chk("str_vld0",  32'(x_if.vld),  32'd1);
        chk("str_dat0",  32'(x_if.data), 32'h11);
        chk("str_lvl0",  32'(level),     32'd1);
        push_data = 8'h22; tick();
        chk("str_dat1",  32'(x_if.data), 32'h22);
        push_data = 8'h33; tick();
        chk("str_dat2",  32'(x_if.data), 32'h33);
        chk("str_vld2",  32'(x_if.vld),  32'd1);
        push_vld = 1'b0; tick();
        chk("str_vldE",  32'(x_if.vld),  32'd0);
        chk("str_lvlE",  32'(level),     32'd0);

        // Backpressure: fill, head stays put, push while full is ignored.
        x_if.rdy = 1'b0;
        exp_q[0] = 8'hA1; exp_q[1] = 8'hA2; exp_q[2] = 8'hA3; exp_q[3] = 8'hA4;
        for (int i = 0; i < 4; i++) begin
            push_vld = 1'b1; push_data = exp_q[i]; tick();
        end
        chk("bp_level",  32'(level),     32'd4);
        chk("bp_prdy",   32'(push_rdy),  32'd0);
        chk("bp_data",   32'(x_if.data), 32'hA1);
        push_data = 8'hEE; tick();
        chk("bp_full_lvl", 32'(level),   32'd4);
        chk("bp_hold",   32'(x_if.data), 32'hA1);
        push_vld = 1'b0;
        x_if.rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_beat_v", 32'(x_if.vld),  32'd1);
            chk("bp_beat_d", 32'(x_if.data), 32'(exp_q[i]));
            tick();
        end
        chk("bp_end_vld", 32'(x_if.vld), 32'd0);
        chk("bp_end_lvl", 32'(level),    32'd0);

        // Gap of 3 idle cycles after each beat.
        x_if.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_vld = 1'b1; push_data = 8'hB1 + 8'(i); tick();
        end
        push_vld = 1'b0;
        gap_cfg  = 4'd3;
        x_if.rdy = 1'b1;
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 0; vpat[4] = 1;
        vpat[5] = 0; vpat[6] = 0; vpat[7] = 0; vpat[8] = 1;
        for (int i = 0; i < 9; i++) begin
            chk("gap_vld", 32'(x_if.vld), 32'(vpat[i]));
            if (i == 4) chk("gap_dat1", 32'(x_if.data), 32'hB2);
            if (i == 8) chk("gap_dat2", 32'(x_if.data), 32'hB3);
            tick();
        end
        gap_cfg = 4'd0;
        tick(); tick(); tick();
        chk("gap_end_vld", 32'(x_if.vld), 32'd0);
        chk("gap_end_lvl", 32'(level),    32'd0);

        // Flush in SEND: only the presented head survives.
        x_if.rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_vld = 1'b1; push_data = 8'hC1 + 8'(i); tick();
        end
        push_vld = 1'b0;
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("fl_vld",    32'(x_if.vld),  32'd1);
        chk("fl_data",   32'(x_if.data), 32'hC1);
        chk("fl_level",  32'(level),     32'd1);
        tick();
        chk("fl_hold",   32'(x_if.data), 32'hC1);
        x_if.rdy = 1'b1; tick();
        chk("fl_end_vld", 32'(x_if.vld), 32'd0);
        chk("fl_end_lvl", 32'(level),    32'd0);
        tick();
        chk("fl_idle",   32'(x_if.vld),  32'd0);

        // Flush with a same-cycle push: push is kept behind the head.
        x_if.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_vld = 1'b1; push_data = 8'hD1 + 8'(i); tick();
        end
        push_data = 8'hD9; flush = 1'b1; tick();
        push_vld = 1'b0; flush = 1'b0;
        chk("flp_level", 32'(level),     32'd2);
        chk("flp_head",  32'(x_if.data), 32'hD1);
        x_if.rdy = 1'b1; tick();
        chk("flp_vld2",  32'(x_if.vld),  32'd1);
        chk("flp_dat2",  32'(x_if.data), 32'hD9);
        tick();
        chk("flp_end",   32'(x_if.vld),  32'd0);
        chk("flp_lvl",   32'(level),     32'd0);

        // Synchronous reset while presenting a word.
        x_if.rdy = 1'b0;
        push_vld = 1'b1; push_data = 8'hE1; tick();
        push_data = 8'hE2; tick();
        push_vld = 1'b0;
        chk("mr_pre_vld", 32'(x_if.vld), 32'd1);
        rst_n = 1'b0; tick();
        chk("mr_vld",    32'(x_if.vld),  32'd0);
        chk("mr_level",  32'(level),     32'd0);
        chk("mr_prdy",   32'(push_rdy),  32'd0);
        rst_n = 1'b1; tick();
        chk("mr_rel_prdy", 32'(push_rdy), 32'd1);
        chk("mr_rel_vld",  32'(x_if.vld), 32'd0);

`ifdef BLOCK_CX_SRC_STATS_EN
        // Five beats with two stalled cycles, then a flush.
        x_if.rdy = 1'b0;
        push_vld = 1'b1; push_data = 8'hF1; tick();
        push_data = 8'hF2; tick();
        push_data = 8'hF3; tick();
        x_if.rdy = 1'b1;
        push_data = 8'hF4; tick();
        push_data = 8'hF5; tick();
        push_vld = 1'b0;
        tick(); tick(); tick();
        chk("st_vld",    32'(x_if.vld),  32'd0);
        chk("st_beat",   32'(beat_cnt),  32'd5);
        chk("st_stall",  32'(stall_cnt), 32'd2);
        flush = 1'b1; tick();
        flush = 1'b0; tick();
        chk("st_fl_beat",  32'(beat_cnt),  32'd5);
        chk("st_fl_stall", 32'(stall_cnt), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
